cmd_queue: RTL and testbench

//  Circular command buffer directly upstream of the issuer; stores cmd_t entries.

---
 rtl/cmd_queue_pkg.sv | 19 +
 rtl/cmd_queue_mem.sv | 27 ++
 rtl/cmd_queue.sv | 150 +++++++++++++++
 tb/tb_cmd_queue.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_queue_pkg.sv
// Shared types for the issuer-side command queue.
package cmd_queue_pkg;

    localparam int unsigned QUEUE_DEPTH = 16;

    typedef struct packed {
        logic [7:0]  id;
        logic [3:0]  dep;
        logic [15:0] payload;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WB_WAIT,
        ACK
    } qstate_t;

endpackage

// File: rtl/cmd_queue_mem.sv
// DEPTH x cmd_t storage: one synchronous write port, one asynchronous read port.
module cmd_queue_mem
    import cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH = QUEUE_DEPTH,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  cmd_t          wdata,
    input  logic [AW-1:0] raddr,
    output cmd_t          rdata
);

    cmd_t mem [DEPTH];

    // Data array carries no reset; validity is tracked by the occupancy count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/cmd_queue.sv
// Circular command buffer feeding the issuer: host push port, issuer read and
// writeback handshakes, with RESERVE slots kept free for writebacks.
module cmd_queue
    import cmd_queue_pkg::*;
#(
    parameter int unsigned DEPTH   = QUEUE_DEPTH,
    parameter int unsigned RESERVE = 1,
    localparam int unsigned CW     = $clog2(DEPTH + 1)
) (
    input  logic          i_clk,
    input  logic          i_rstn,
    input  logic          i_push_valid,
    input  cmd_t          i_push_cmd,
    output logic          o_push_ready,
    input  logic          i_rd_queue,
    input  logic          i_wr_queue,
    input  cmd_t          i_wb_cmd,
    output cmd_t          o_cmd,
    output logic          o_ack_queue,
    output logic          o_empty,
    output logic          o_full,
    output logic [CW-1:0] o_count
);

    localparam int unsigned AW         = $clog2(DEPTH);
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [CW-1:0] PUSH_LIM = CW'(DEPTH - RESERVE);

    qstate_t       state, state_nxt;
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          rd_q, wr_q;
    logic          do_pop, do_wb, do_push;
    logic          mem_we;
    cmd_t          mem_wdata, mem_rdata, cmd_q;

    // Issuer requests are registered; the sample taken during ACK is discarded
    // because the issuer only drops its level request after seeing the ack.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_q <= 1'b0;
            wr_q <= 1'b0;
        end else begin
            rd_q <= i_rd_queue && (state != ACK);
            wr_q <= i_wr_queue && (state != ACK);
        end
    end

    // Issuer FSM state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Issuer FSM next state and pop/writeback decisions; writeback wins over read.
    always_comb begin
        state_nxt = state;
        do_pop    = 1'b0;
        do_wb     = 1'b0;
        unique case (state)
            IDLE: begin
                if (wr_q) begin
                    if (count < DEPTH_C) begin
                        do_wb     = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        state_nxt = WB_WAIT;
                    end
                end else if (rd_q) begin
                    if (count != '0) begin
                        do_pop    = 1'b1;
                        state_nxt = ACK;
                    end else begin
                        state_nxt = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                if (!rd_q) begin
                    state_nxt = IDLE;
                end else if (count != '0) begin
                    do_pop    = 1'b1;
                    state_nxt = ACK;
                end
            end
            WB_WAIT: begin
                if (!wr_q) begin
                    state_nxt = IDLE;
                end else if (count < DEPTH_C) begin
                    do_wb     = 1'b1;
                    state_nxt = ACK;
                end
            end
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign o_push_ready = (count < PUSH_LIM) && !do_wb;
    assign do_push      = i_push_valid && o_push_ready;
    assign mem_we       = do_wb || do_push;
    assign mem_wdata    = do_wb ? i_wb_cmd : i_push_cmd;

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (mem_we) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) + CW'(do_wb) - CW'(do_pop);
        end
    end

    // Popped entry is captured and held until the next pop.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            cmd_q <= '0;
        end else if (do_pop) begin
            cmd_q <= mem_rdata;
        end
    end

    cmd_queue_mem #(
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (i_clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (mem_wdata),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

    assign o_cmd       = cmd_q;
    assign o_ack_queue = (state == ACK);
    assign o_empty     = (count == '0);
    assign o_full      = (count == DEPTH_C);
    assign o_count     = count;

endmodule

// File: tb/tb_cmd_queue.sv
// Scoreboard bench for cmd_queue: a FIFO reference model feeds expected
// responses to a monitor that checks every ack.
module tb_cmd_queue;
    import cmd_queue_pkg::*;

    localparam int unsigned DEPTH   = 16;
    localparam int unsigned RESERVE = 1;
    localparam int unsigned CW      = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rstn;
    logic          push_valid;
    cmd_t          push_cmd;
    logic          push_ready;
    logic          rd;
    logic          wr;
    cmd_t          wb_cmd;
    cmd_t          o_cmd;
    logic          o_ack_queue;
    logic          o_empty;
    logic          o_full;
    logic [CW-1:0] o_count;

    cmd_queue #(
        .DEPTH   (DEPTH),
        .RESERVE (RESERVE)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_push_valid (push_valid),
        .i_push_cmd   (push_cmd),
        .o_push_ready (push_ready),
        .i_rd_queue   (rd),
        .i_wr_queue   (wr),
        .i_wb_cmd     (wb_cmd),
        .o_cmd        (o_cmd),
        .o_ack_queue  (o_ack_queue),
        .o_empty      (o_empty),
        .o_full       (o_full),
        .o_count      (o_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit   is_rd;
        cmd_t cmd;
    } exp_t;

    cmd_t ref_q[$];
    exp_t exp_q[$];
    int   pending_rd = 0;
    int   checks     = 0;
    int   passed     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    endtask

    // Hand queued reads the oldest entries of the model FIFO.
    function automatic void service();
        while (pending_rd > 0 && ref_q.size() > 0) begin
            exp_t e;
            e.is_rd = 1'b1;
            e.cmd   = ref_q.pop_front();
            exp_q.push_back(e);
            pending_rd--;
        end
    endfunction

    function automatic cmd_t mk(input int id);
        cmd_t c;
        c.id      = 8'(id);
        c.dep     = 4'($urandom);
        c.payload = 16'($urandom);
        return c;
    endfunction

    // Monitor: every ack consumes one expected response.
    always @(negedge clk) begin
        if (rstn && o_ack_queue) begin
            if (exp_q.size() == 0) begin
                check("unexpected_ack", 32'(o_ack_queue), 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_rd) check("rd_cmd", 32'(o_cmd), 32'(e.cmd));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(output int lat);
        lat = -1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (o_ack_queue) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push(input cmd_t c, output bit acc);
        push_valid = 1'b1;
        push_cmd   = c;
        @(negedge clk);
        acc = push_ready;
        @(posedge clk);
        if (acc) begin
            ref_q.push_back(c);
            service();
        end
        #1;
        push_valid = 1'b0;
    endtask

    task automatic do_read(input int exp_lat);
        int lat;
        pending_rd++;
        service();
        rd = 1'b1;
        wait_ack(lat);
        rd = 1'b0;
        if (lat < 0) check("rd_timeout", 32'd0, 32'd1);
        else if (exp_lat >= 0) check("rd_latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic do_wb(input cmd_t c, input int exp_lat);
        int   lat;
        exp_t e;
        ref_q.push_back(c);
        e.is_rd = 1'b0;
        e.cmd   = c;
        exp_q.push_back(e);
        service();
        wr     = 1'b1;
        wb_cmd = c;
        wait_ack(lat);
        wr = 1'b0;
        if (lat < 0) check("wb_timeout", 32'd0, 32'd1);
        else if (exp_lat >= 0) check("wb_latency", 32'(lat), 32'(exp_lat));
    endtask

    task automatic apply_reset();
        rstn = 1'b0;
        rd   = 1'b0;
        wr   = 1'b0;
        push_valid = 1'b0;
        ref_q.delete();
        exp_q.delete();
        pending_rd = 0;
        step();
        rstn = 1'b1;
        step();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit acc;
        int n;
        int lat;
        cmd_t c;

        rstn       = 1'b0;
        push_valid = 1'b0;
        push_cmd   = '0;
        rd         = 1'b0;
        wr         = 1'b0;
        wb_cmd     = '0;
        step();
        step();
        rstn = 1'b1;
        step();

        // Reset state
        check("rst_cmd", 32'(o_cmd), 32'd0);
        check("rst_ack", 32'(o_ack_queue), 32'd0);
        check("rst_ready", 32'(push_ready), 32'd1);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_full", 32'(o_full), 32'd0);
        check("rst_count", 32'(o_count), 32'd0);

        // 1. Basic FIFO order and latency
        for (int i = 1; i <= 3; i++) begin
            push(mk(i), acc);
            check("t1_push_acc", 32'(acc), 32'd1);
        end
        check("t1_count", 32'(o_count), 32'd3);
        do_read(2);
        check("t1_cmd_hold", 32'(o_cmd.id), 32'd1);
        do_read(2);
        do_read(2);
        check("t1_empty", 32'(o_empty), 32'd1);

        // 2. Read on empty waits in RD_WAIT until a push arrives
        pending_rd++;
        service();
        rd = 1'b1;
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_rd_wait_state", 32'(dut.state), 32'(RD_WAIT));
            check("t2_no_ack", 32'(o_ack_queue), 32'd0);
            step();
        end
        push(mk(7), acc);
        check("t2_push_acc", 32'(acc), 32'd1);
        wait_ack(lat);
        rd = 1'b0;
        if (lat < 0) check("t2_rd_timeout", 32'd0, 32'd1);
        check("t2_count", 32'(o_count), 32'd0);

        // 3. Host pushes stop at DEPTH-RESERVE; writeback uses the reserved slot
        n = 0;
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            push(mk(20 + i), acc);
            if (!acc) break;
            n++;
        end
        check("t3_host_pushes", 32'(n), 32'(DEPTH - RESERVE));
        check("t3_count", 32'(o_count), 32'(DEPTH - RESERVE));
        check("t3_ready_low", 32'(push_ready), 32'd0);
        do_wb(mk(9), 2);
        check("t3_count_full", 32'(o_count), 32'(DEPTH));
        check("t3_full", 32'(o_full), 32'd1);
        for (int i = 0; i < int'(DEPTH); i++) do_read(2);
        check("t3_empty", 32'(o_empty), 32'd1);

        // 4. Writeback into a full queue waits; reset drops it
        for (int i = 0; i < int'(DEPTH - RESERVE); i++) push(mk(60 + i), acc);
        do_wb(mk(80), 2);
        check("t4_full", 32'(o_full), 32'd1);
        wr     = 1'b1;
        wb_cmd = mk(99);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_wb_wait_state", 32'(dut.state), 32'(WB_WAIT));
            check("t4_no_ack", 32'(o_ack_queue), 32'd0);
            step();
        end
        rstn = 1'b0;
        wr   = 1'b0;
        ref_q.delete();
        exp_q.delete();
        pending_rd = 0;
        @(negedge clk);
        check("t4_rst_count", 32'(o_count), 32'd0);
        check("t4_rst_state", 32'(dut.state), 32'(IDLE));
        step();
        rstn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("t4_post_rst_ack", 32'(o_ack_queue), 32'd0);
            step();
        end
        check("t4_post_rst_empty", 32'(o_empty), 32'd1);

        // 5. Writeback blocks a same-cycle push; pop plus push keeps count
        push(mk(50), acc);
        push(mk(51), acc);
        begin
            exp_t e;
            c = mk(52);
            ref_q.push_back(c);
            e.is_rd = 1'b0;
            e.cmd   = c;
            exp_q.push_back(e);
        end
        wr     = 1'b1;
        wb_cmd = c;
        step();
        push_valid = 1'b1;
        push_cmd   = mk(53);
        @(negedge clk);
        check("t5_ready_in_wb", 32'(push_ready), 32'd0);
        step();
        push_valid = 1'b0;
        @(negedge clk);
        check("t5_wb_ack", 32'(o_ack_queue), 32'd1);
        step();
        wr = 1'b0;
        check("t5_count_wb", 32'(o_count), 32'd3);
        pending_rd++;
        service();
        rd = 1'b1;
        step();
        c          = mk(54);
        push_valid = 1'b1;
        push_cmd   = c;
        @(negedge clk);
        check("t5_ready_in_pop", 32'(push_ready), 32'd1);
        @(posedge clk);
        ref_q.push_back(c);
        service();
        #1;
        push_valid = 1'b0;
        @(negedge clk);
        check("t5_rd_ack", 32'(o_ack_queue), 32'd1);
        step();
        rd = 1'b0;
        check("t5_count_pop_push", 32'(o_count), 32'd3);
        for (int i = 0; i < 3; i++) do_read(2);
        check("t5_empty", 32'(o_empty), 32'd1);

        // 6. Pointer wrap with an offset fill and random gaps
        for (int i = 0; i < 5; i++) push(mk(100 + i), acc);
        for (int i = 0; i < 40; i++) begin
            push(mk(105 + i), acc);
            check("t6_push_acc", 32'(acc), 32'd1);
            repeat ($urandom_range(0, 2)) step();
            do_read(2);
        end
        for (int i = 0; i < 5; i++) do_read(2);
        check("t6_empty", 32'(o_empty), 32'd1);
        check("t6_scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
